// File: rtl/jitdom_btb_if.sv
// Shared types and the lookup/resolution bundle between fetch, execute and the domain-aware BTB.
// Lookup outputs are combinational; updates are fire-and-forget (no backpressure).
package jitdom_btb_pkg;
  localparam int unsigned VLEN = 32;

  typedef logic [2:0] dom_t;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
    logic            is_mispredict;
    logic            is_taken;
    cf_t             cf_type;
    dom_t            expdom;
  } bp_resolve_t;
endpackage

interface jitdom_btb_if;
  import jitdom_btb_pkg::*;

  logic            flush_i;
  logic            debug_mode_i;
  logic [VLEN-1:0] vpc_i;
  dom_t            curdom_i;
  bp_resolve_t     resolved_branch_i;
  dom_t            update_dom_i;
  logic            btb_valid_o;
  logic [VLEN-1:0] btb_target_o;
  dom_t            btb_expdom_o;

  modport master (
    output flush_i, debug_mode_i, vpc_i, curdom_i, resolved_branch_i, update_dom_i,
    input  btb_valid_o, btb_target_o, btb_expdom_o
  );

  modport slave (
    input  flush_i, debug_mode_i, vpc_i, curdom_i, resolved_branch_i, update_dom_i,
    output btb_valid_o, btb_target_o, btb_expdom_o
  );
endinterface

// File: rtl/jitdom_btb.sv
// Direct-mapped BTB learning JumpR targets tagged by PC and source JIT domain.
// Lookup latency 0, write visible next cycle; no backpressure, one update per cycle accepted.
module jitdom_btb
  import jitdom_btb_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  jitdom_btb_if.slave btb
);
  localparam int unsigned OFF  = 1;
  localparam int unsigned IDX  = $clog2(NR_ENTRIES);
  localparam int unsigned TAGW = VLEN - OFF - IDX;

  logic [NR_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]       tag_q    [NR_ENTRIES];
  dom_t                  srcdom_q [NR_ENTRIES];
  logic [VLEN-1:0]       target_q [NR_ENTRIES];
  dom_t                  expdom_q [NR_ENTRIES];

  bp_resolve_t     rb;
  logic            learn;
  logic [IDX-1:0]  wr_idx;
  logic [TAGW-1:0] wr_tag;
  logic [IDX-1:0]  rd_idx;
  logic [TAGW-1:0] rd_tag;
  logic            hit;

  assign rb     = btb.resolved_branch_i;
  assign wr_idx = rb.pc[OFF+IDX-1:OFF];
  assign wr_tag = rb.pc[VLEN-1:OFF+IDX];
  assign rd_idx = btb.vpc_i[OFF+IDX-1:OFF];
  assign rd_tag = btb.vpc_i[VLEN-1:OFF+IDX];

  // Only mispredicted indirect jumps teach the table; correct predictions leave it alone.
  assign learn = rb.valid & rb.is_mispredict & (rb.cf_type == JumpR) & ~btb.debug_mode_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        tag_q[i]    <= '0;
        srcdom_q[i] <= '0;
        target_q[i] <= '0;
        expdom_q[i] <= '0;
      end
    end else begin
      // Flush dominates a coincident learn so the table always ends fully invalid.
      if (btb.flush_i) begin
        valid_q <= '0;
      end else if (learn) begin
        valid_q[wr_idx] <= 1'b1;
      end
      if (learn) begin
        tag_q[wr_idx]    <= wr_tag;
        srcdom_q[wr_idx] <= btb.update_dom_i;
        target_q[wr_idx] <= rb.target_address;
        expdom_q[wr_idx] <= rb.expdom;
      end
    end
  end

  assign hit = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag) & (srcdom_q[rd_idx] == btb.curdom_i);

  assign btb.btb_valid_o  = hit;
  assign btb.btb_target_o = hit ? target_q[rd_idx] : '0;
  assign btb.btb_expdom_o = hit ? expdom_q[rd_idx] : btb.curdom_i;

  logic unused_bits;
  assign unused_bits = ^{btb.vpc_i[OFF-1:0], rb.pc[OFF-1:0], rb.is_taken};
endmodule

// File: tb/tb_jitdom_btb.sv
// Directed bench for jitdom_btb: learn, domain isolation, aliasing, ignored updates, flush, async reset.
module tb_jitdom_btb;
  import jitdom_btb_pkg::*;

  logic clk;
  logic rst_ni;
  int   total;
  int   bad;

  jitdom_btb_if bif ();

  jitdom_btb #(.NR_ENTRIES(16)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .btb   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [VLEN-1:0] pc, input dom_t dom,
                        input logic exp_v, input logic [VLEN-1:0] exp_t, input dom_t exp_d);
    bif.vpc_i    = pc;
    bif.curdom_i = dom;
    #1;
    chk({tag, ".valid"}, 64'(bif.btb_valid_o), 64'(exp_v));
    chk({tag, ".target"}, 64'(bif.btb_target_o), 64'(exp_t));
    chk({tag, ".expdom"}, 64'(bif.btb_expdom_o), 64'(exp_d));
  endtask

  task automatic set_res(input logic [VLEN-1:0] pc, input logic [VLEN-1:0] tgt, input cf_t cf,
                         input logic misp, input dom_t ed, input dom_t ud);
    bif.resolved_branch_i = '{valid: 1'b1, pc: pc, target_address: tgt, is_mispredict: misp,
                              is_taken: 1'b1, cf_type: cf, expdom: ed};
    bif.update_dom_i = ud;
  endtask

  task automatic clear_res();
    bif.resolved_branch_i = '0;
    bif.update_dom_i      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    clear_res();
  endtask

  localparam logic [VLEN-1:0] PA = 32'h8000_0040;
  localparam logic [VLEN-1:0] PB = 32'h8000_0060;  // same index as PA, different tag
  localparam logic [VLEN-1:0] PC = 32'h8000_0100;
  localparam logic [VLEN-1:0] PE = 32'h8000_0210;
  localparam logic [VLEN-1:0] PG = 32'h8000_0300;

  initial begin
    total = 0;
    bad   = 0;
    rst_ni = 1'b0;
    bif.flush_i      = 1'b0;
    bif.debug_mode_i = 1'b0;
    bif.vpc_i        = '0;
    bif.curdom_i     = '0;
    clear_res();

    #2;
    lookup("reset", PA, 3'd2, 1'b0, '0, 3'd2);
    @(negedge clk);
    rst_ni = 1'b1;

    // learn PA; lookup in the write cycle still misses
    set_res(PA, 32'h8000_1000, JumpR, 1'b1, 3'd3, 3'd1);
    lookup("write_cycle", PA, 3'd1, 1'b0, '0, 3'd1);
    tick();
    lookup("hit_a", PA, 3'd1, 1'b1, 32'h8000_1000, 3'd3);
    lookup("dom_iso", PA, 3'd2, 1'b0, '0, 3'd2);

    set_res(PB, 32'h8000_2000, JumpR, 1'b1, 3'd5, 3'd1);
    tick();
    lookup("alias_old", PA, 3'd1, 1'b0, '0, 3'd1);
    lookup("alias_new", PB, 3'd1, 1'b1, 32'h8000_2000, 3'd5);

    // ignored updates
    set_res(PC, 32'h8000_4000, Branch, 1'b1, 3'd3, 3'd1);
    tick();
    lookup("branch_ign", PC, 3'd1, 1'b0, '0, 3'd1);
    set_res(PC, 32'h8000_4000, Jump, 1'b1, 3'd3, 3'd1);
    tick();
    lookup("jump_ign", PC, 3'd1, 1'b0, '0, 3'd1);
    set_res(PC, 32'h8000_4000, JumpR, 1'b0, 3'd3, 3'd1);
    tick();
    lookup("nomisp_ign", PC, 3'd1, 1'b0, '0, 3'd1);
    set_res(PB, 32'h8000_7000, JumpR, 1'b0, 3'd2, 3'd1);
    tick();
    lookup("nomisp_keep", PB, 3'd1, 1'b1, 32'h8000_2000, 3'd5);
    bif.debug_mode_i = 1'b1;
    set_res(PC, 32'h8000_4000, JumpR, 1'b1, 3'd3, 3'd1);
    tick();
    lookup("debug_ign", PC, 3'd1, 1'b0, '0, 3'd1);
    lookup("debug_serve", PB, 3'd1, 1'b1, 32'h8000_2000, 3'd5);
    bif.debug_mode_i = 1'b0;

    // fill four entries, then flush together with a learn
    for (int i = 0; i < 4; i++) begin
      set_res(32'h8000_0200 + 32'(4 * i), 32'h9000_0000 + 32'(i), JumpR, 1'b1, 3'(i), 3'd4);
      tick();
    end
    lookup("fill3", 32'h8000_020C, 3'd4, 1'b1, 32'h9000_0003, 3'd3);
    lookup("fill0", 32'h8000_0200, 3'd4, 1'b1, 32'h9000_0000, 3'd0);
    bif.flush_i = 1'b1;
    set_res(PE, 32'h9000_0010, JumpR, 1'b1, 3'd6, 3'd4);
    tick();
    bif.flush_i = 1'b0;
    lookup("flush0", 32'h8000_0200, 3'd4, 1'b0, '0, 3'd4);
    lookup("flush1", 32'h8000_0204, 3'd4, 1'b0, '0, 3'd4);
    lookup("flush2", 32'h8000_0208, 3'd4, 1'b0, '0, 3'd4);
    @(negedge clk);
    lookup("flush3", 32'h8000_020C, 3'd4, 1'b0, '0, 3'd4);
    lookup("flush_new", PE, 3'd4, 1'b0, '0, 3'd4);
    lookup("flush_b", PB, 3'd1, 1'b0, '0, 3'd1);

    // learn, then async reset mid-cycle
    set_res(PG, 32'h8000_3000, JumpR, 1'b1, 3'd2, 3'd1);
    tick();
    lookup("pre_rst", PG, 3'd1, 1'b1, 32'h8000_3000, 3'd2);
    @(negedge clk);
    #1;
    rst_ni = 1'b0;
    lookup("async_rst", PG, 3'd1, 1'b0, '0, 3'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    set_res(PG, 32'h8000_3000, JumpR, 1'b1, 3'd2, 3'd1);
    tick();
    lookup("post_rst_learn", PG, 3'd1, 1'b1, 32'h8000_3000, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
